ip_rx: RTL and testbench



---
 rtl/ip_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_ip_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_rx.sv
// ip_rx: MAC/IPv4 header parser and filter feeding the UDP/ICMP receivers.
// Define IP_RX_CHECKSUM_EN to build and enforce the IPv4 header checksum.
module ip_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  input  logic [7:0]  mac_rx_data,
  input  logic        mac_rx_valid,
  input  logic        mac_rx_end,
  output logic [7:0]  ip_rx_data,
  output logic        ip_rx_valid,
  output logic        ip_rx_start,
  output logic        ip_rx_end,
  output logic        ip_rx_error,
  output logic [7:0]  ip_rx_type,
  output logic [15:0] ip_rx_length,
  output logic [31:0] sour_ip_addr,
  output logic [47:0] sour_mac_addr
);

  typedef enum logic [2:0] {
    IDLE, MAC_HEAD, IP_HEAD, PAYLOAD, DROP
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, idx;
  logic        uc_ok, bc_ok, uc_n, bc_n;
  logic [47:0] smac_sh;
  logic [31:0] sip_sh;
  logic [7:0]  proto_sh;
  logic [15:0] tot_len;
  logic [7:0]  mac_b, ip_b;
  logic        fwd, first, last, trunc, hdr_ok;
  logic        in_hdr, csum_ok;

  assign idx    = (state == IDLE) ? 16'd0 : cnt;
  assign in_hdr = mac_rx_valid &&
                  (state == IDLE || state == MAC_HEAD ||
                   state == IP_HEAD);

  always_comb begin
    mac_b = 8'h00;
    case (idx[2:0])
      3'd0:    mac_b = local_mac_addr[47:40];
      3'd1:    mac_b = local_mac_addr[39:32];
      3'd2:    mac_b = local_mac_addr[31:24];
      3'd3:    mac_b = local_mac_addr[23:16];
      3'd4:    mac_b = local_mac_addr[15:8];
      3'd5:    mac_b = local_mac_addr[7:0];
      default: mac_b = 8'h00;
    endcase
  end

  // bytes 30..33 land on idx[1:0] = 2,3,0,1
  always_comb begin
    ip_b = 8'h00;
    case (idx[1:0])
      2'd2:    ip_b = local_ip_addr[31:24];
      2'd3:    ip_b = local_ip_addr[23:16];
      2'd0:    ip_b = local_ip_addr[15:8];
      default: ip_b = local_ip_addr[7:0];
    endcase
  end

`ifdef IP_RX_CHECKSUM_EN
  logic [19:0] acc, sum;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [7:0]  hi;

  always_comb begin
    sum   = acc + {4'd0, hi, mac_rx_data};
    fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    fold2 = fold1[15:0] + {15'd0, fold1[16]};
  end

  assign csum_ok = (fold2 == 16'hFFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      hi  <= '0;
    end else if (mac_rx_valid && state == IP_HEAD) begin
      if (!idx[0]) begin
        hi <= mac_rx_data;
        if (idx == 16'd14) acc <= '0;
      end else begin
        acc <= sum;
      end
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    uc_n    = uc_ok;
    bc_n    = bc_ok;
    fwd     = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    trunc   = 1'b0;
    hdr_ok  = 1'b0;
    if (mac_rx_valid) begin
      unique case (state)
        IDLE, MAC_HEAD: begin
          state_n = MAC_HEAD;
          if (idx < 16'd6) begin
            uc_n = ((idx == 16'd0) ? 1'b1 : uc_ok) &
                   (mac_rx_data == mac_b);
            bc_n = ((idx == 16'd0) ? 1'b1 : bc_ok) &
                   (mac_rx_data == 8'hFF);
            if (!uc_n && !bc_n) state_n = DROP;
          end
          if (idx == 16'd12 && mac_rx_data != 8'h08)
            state_n = DROP;
          if (idx == 16'd13)
            state_n = (mac_rx_data == 8'h00) ? IP_HEAD : DROP;
          if (mac_rx_end) state_n = IDLE;
        end
        IP_HEAD: begin
          if (idx == 16'd14 && mac_rx_data != 8'h45)
            state_n = DROP;
          if (idx == 16'd17 &&
              {tot_len[15:8], mac_rx_data} < 16'd20)
            state_n = DROP;
          if (idx >= 16'd30 && mac_rx_data != ip_b)
            state_n = DROP;
          if (idx == 16'd33) begin
            if (state_n == IP_HEAD && csum_ok) begin
              hdr_ok = 1'b1;
              if (tot_len == 16'd20)
                state_n = mac_rx_end ? IDLE : DROP;
              else
                state_n = PAYLOAD;
            end else begin
              state_n = DROP;
            end
          end
          if (mac_rx_end) state_n = IDLE;
        end
        PAYLOAD: begin
          fwd   = 1'b1;
          first = (idx == 16'd34);
          last  = ({1'b0, idx} ==
                   {1'b0, tot_len} + 17'd13);
          if (last)
            state_n = mac_rx_end ? IDLE : DROP;
          else if (mac_rx_end) begin
            trunc   = 1'b1;
            state_n = IDLE;
          end else if (idx == 16'hFFFF)
            state_n = DROP;
        end
        DROP: if (mac_rx_end) state_n = IDLE;
        default: state_n = DROP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DROP;
      cnt   <= '0;
      uc_ok <= 1'b0;
      bc_ok <= 1'b0;
    end else begin
      state <= state_n;
      uc_ok <= uc_n;
      bc_ok <= bc_n;
      if (mac_rx_valid)
        cnt <= (idx == 16'hFFFF) ? idx : idx + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smac_sh  <= '0;
      sip_sh   <= '0;
      proto_sh <= '0;
      tot_len  <= '0;
    end else if (in_hdr) begin
      if (idx >= 16'd6 && idx <= 16'd11)
        smac_sh <= {smac_sh[39:0], mac_rx_data};
      if (idx == 16'd16) tot_len[15:8] <= mac_rx_data;
      if (idx == 16'd17) tot_len[7:0]  <= mac_rx_data;
      if (idx == 16'd23) proto_sh <= mac_rx_data;
      if (idx >= 16'd26 && idx <= 16'd29)
        sip_sh <= {sip_sh[23:0], mac_rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ip_rx_data    <= '0;
      ip_rx_valid   <= 1'b0;
      ip_rx_start   <= 1'b0;
      ip_rx_end     <= 1'b0;
      ip_rx_error   <= 1'b0;
      ip_rx_type    <= '0;
      ip_rx_length  <= '0;
      sour_ip_addr  <= '0;
      sour_mac_addr <= '0;
    end else begin
      ip_rx_valid <= fwd;
      ip_rx_start <= first;
      ip_rx_end   <= last;
      ip_rx_error <= trunc;
      if (fwd) ip_rx_data <= mac_rx_data;
      if (hdr_ok) begin
        ip_rx_type    <= proto_sh;
        ip_rx_length  <= tot_len - 16'd20;
        sour_ip_addr  <= sip_sh;
        sour_mac_addr <= smac_sh;
      end
    end
  end

endmodule

// File: tb/tb_ip_rx.sv
// tb_ip_rx: directed frames for ip_rx with a queue of expected payload
// bytes stamped with the cycle each one must appear on the output.
module tb_ip_rx;

  localparam logic [47:0] LMAC = 48'h000a_3501_0203;
  localparam logic [47:0] OMAC = 48'h000a_3501_0204;
  localparam logic [47:0] BMAC = 48'hffff_ffff_ffff;
  localparam logic [47:0] SMAC = 48'h0211_2233_4455;
  localparam logic [31:0] LIP  = 32'hc0a8_0102;
  localparam logic [31:0] SIP  = 32'hc0a8_0164;

`ifdef IP_RX_CHECKSUM_EN
  localparam bit CK_OK = 1'b0;
`else
  localparam bit CK_OK = 1'b1;
`endif

  typedef struct packed {
    logic [7:0]  data;
    logic        s;
    logic        e;
    logic        er;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mac_rx_data;
  logic        mac_rx_valid;
  logic        mac_rx_end;
  logic [7:0]  ip_rx_data;
  logic        ip_rx_valid;
  logic        ip_rx_start;
  logic        ip_rx_end;
  logic        ip_rx_error;
  logic [7:0]  ip_rx_type;
  logic [15:0] ip_rx_length;
  logic [31:0] sour_ip_addr;
  logic [47:0] sour_mac_addr;

  exp_t        sb[$];
  logic [7:0]  frm[$];
  logic [31:0] cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  m_type;
  logic [15:0] m_len;
  logic [31:0] m_ip;
  logic [47:0] m_mac;
  exp_t        got, want;

  ip_rx dut (
    .clk(clk), .rst(rst),
    .local_mac_addr(LMAC), .local_ip_addr(LIP),
    .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid),
    .mac_rx_end(mac_rx_end),
    .ip_rx_data(ip_rx_data), .ip_rx_valid(ip_rx_valid),
    .ip_rx_start(ip_rx_start), .ip_rx_end(ip_rx_end),
    .ip_rx_error(ip_rx_error), .ip_rx_type(ip_rx_type),
    .ip_rx_length(ip_rx_length), .sour_ip_addr(sour_ip_addr),
    .sour_mac_addr(sour_mac_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ip_rx_valid !== 1'b0 || ip_rx_start !== 1'b0 ||
        ip_rx_end !== 1'b0 || ip_rx_error !== 1'b0) begin
      n_assert++;
      assert (ip_rx_valid === 1'b1 && sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_out: v=%b s=%b e=%b er=%b pend=%0d, required no output",
               ip_rx_valid, ip_rx_start, ip_rx_end, ip_rx_error, sb.size());
      end
      if (ip_rx_valid === 1'b1 && sb.size() > 0) begin
        want = sb.pop_front();
        got  = {ip_rx_data, ip_rx_start, ip_rx_end, ip_rx_error, cyc};
        n_assert++;
        assert (got === want) else begin
          n_fail++;
          $error("FAIL payload: got d=%h s=%b e=%b er=%b cyc=%0d, required d=%h s=%b e=%b er=%b cyc=%0d",
                 got.data, got.s, got.e, got.er, got.cyc,
                 want.data, want.s, want.e, want.er, want.cyc);
        end
        if (want.s) begin
          n_assert++;
          assert (ip_rx_type === m_type) else begin
            n_fail++;
            $error("FAIL type: got %h required %h", ip_rx_type, m_type);
          end
          n_assert++;
          assert (ip_rx_length === m_len) else begin
            n_fail++;
            $error("FAIL length: got %0d required %0d", ip_rx_length, m_len);
          end
          n_assert++;
          assert (sour_ip_addr === m_ip) else begin
            n_fail++;
            $error("FAIL sour_ip: got %h required %h", sour_ip_addr, m_ip);
          end
          n_assert++;
          assert (sour_mac_addr === m_mac) else begin
            n_fail++;
            $error("FAIL sour_mac: got %h required %h", sour_mac_addr, m_mac);
          end
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    n_assert++;
    assert ({ip_rx_data, ip_rx_valid, ip_rx_start, ip_rx_end,
             ip_rx_error, ip_rx_type, ip_rx_length,
             sour_ip_addr, sour_mac_addr} === '0) else begin
      n_fail++;
      $error("FAIL %s: outputs v=%b d=%h len=%0d ip=%h, required all zero",
             tag, ip_rx_valid, ip_rx_data, ip_rx_length, sour_ip_addr);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mac_rx_valid = 1'b0;
      mac_rx_end   = 1'b0;
      rst          = 1'b0;
    end
  endtask

  task automatic settle(input string tag);
    idle(4);
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_drain: %0d bytes still pending, required 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                       input logic [7:0] vihl, input logic [15:0] tlen,
                       input logic [7:0] proto, input logic [31:0] sip,
                       input logic [31:0] dip, input bit corrupt,
                       input int pad, input int trunc);
    logic [7:0]  h[20];
    logic [31:0] s;
    logic [15:0] ck;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dmac[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(SMAC[8*(5-i) +: 8]);
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    h[0] = vihl;        h[1] = 8'h00;
    h[2] = tlen[15:8];  h[3] = tlen[7:0];
    h[4] = 8'h12;       h[5] = 8'h34;
    h[6] = 8'h40;       h[7] = 8'h00;
    h[8] = 8'h40;       h[9] = proto;
    h[10] = 8'h00;      h[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      h[12+i] = sip[8*(3-i) +: 8];
      h[16+i] = dip[8*(3-i) +: 8];
    end
    s = 0;
    for (int k = 0; k < 10; k++) s = s + {16'd0, h[2*k], h[2*k+1]};
    while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    ck = ~s[15:0];
    h[10] = ck[15:8];
    h[11] = ck[7:0] ^ {7'd0, corrupt};
    for (int i = 0; i < 20; i++) frm.push_back(h[i]);
    for (int i = 20; i < int'(tlen); i++) frm.push_back(8'($urandom));
    for (int i = 0; i < pad; i++) frm.push_back(8'h00);
    if (trunc > 0) while (frm.size() > trunc) void'(frm.pop_back());
    m_type = proto;
    m_len  = tlen - 16'd20;
    m_ip   = sip;
    m_mac  = SMAC;
  endtask

  task automatic send(input int plen, input bit ok,
                      input int gap_pct, input int rst_at);
    int   n;
    exp_t e;
    n = frm.size();
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        @(posedge clk); #1;
        mac_rx_valid = 1'b0;
        mac_rx_end   = 1'b0;
      end
      @(posedge clk); #1;
      mac_rx_data  = frm[i];
      mac_rx_valid = 1'b1;
      mac_rx_end   = (i == n - 1);
      rst          = (i == rst_at);
      if (ok && (rst_at < 0 || i < rst_at) && i >= 34 && i < 34 + plen) begin
        e.data = frm[i];
        e.s    = (i == 34);
        e.e    = (i == 33 + plen);
        e.er   = (i == n - 1) && (i < 33 + plen);
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        @(negedge clk);
        chk_zero("rst_mid_frame");
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    mac_rx_data  = 8'h00;
    mac_rx_valid = 1'b0;
    mac_rx_end   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    // reset parks the parser in DROP until an end-of-frame is seen
    @(posedge clk); #1;
    mac_rx_valid = 1'b1;
    mac_rx_end   = 1'b1;
    idle(2);

    build(LMAC, 16'h0800, 8'h45, 16'h0030, 8'h11, SIP, LIP, 0, 18, 0);
    send(28, 1, 0, -1);
    settle("udp");

    build(BMAC, 16'h0800, 8'h45, 16'h0054, 8'h01, 32'h0a00_0001, LIP, 0, 0, 0);
    send(64, 1, 30, -1);
    settle("icmp_gaps");

    build(LMAC, 16'h0806, 8'h45, 16'h0030, 8'h11, SIP, LIP, 0, 18, 0);
    send(28, 0, 0, -1);
    build(LMAC, 16'h0800, 8'h45, 16'h0030, 8'h11, SIP, LIP + 1, 0, 18, 0);
    send(28, 0, 0, -1);
    build(LMAC, 16'h0800, 8'h46, 16'h0030, 8'h11, SIP, LIP, 0, 18, 0);
    send(28, 0, 0, -1);
    build(OMAC, 16'h0800, 8'h45, 16'h0030, 8'h11, SIP, LIP, 0, 18, 0);
    send(28, 0, 0, -1);
    build(LMAC, 16'h0800, 8'h45, 16'h002e, 8'h06, 32'h0102_0304, LIP, 0, 0, 0);
    send(26, 1, 0, -1);
    settle("rejects");

    build(LMAC, 16'h0800, 8'h45, 16'h0030, 8'h11, SIP, LIP, 1, 18, 0);
    send(28, CK_OK, 0, -1);
    settle("bad_csum");

    build(LMAC, 16'h0800, 8'h45, 16'd20, 8'h11, SIP, LIP, 0, 26, 0);
    send(0, 1, 0, -1);
    build(LMAC, 16'h0800, 8'h45, 16'd21, 8'h11, SIP + 7, LIP, 0, 25, 0);
    send(1, 1, 0, -1);
    settle("short_len");

    build(LMAC, 16'h0800, 8'h45, 16'd100, 8'h11, SIP, LIP, 0, 0, 61);
    send(80, 1, 0, -1);
    settle("trunc");

    build(LMAC, 16'h0800, 8'h45, 16'h0030, 8'h11, SIP, LIP, 0, 18, 0);
    send(28, 1, 0, 40);
    build(BMAC, 16'h0800, 8'h45, 16'h0030, 8'h11, 32'h0a0b_0c0d, LIP, 0, 18, 0);
    send(28, 1, 0, -1);
    settle("rst_frame");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
